gol_engine: RTL and testbench

- Parametrised, row-serial Conway-style cellular automaton engine.
- Holds a NUM_ROWS x NUM_COLS cell array and computes one generation per accepted step request, one row per cycle, into a shadow buffer.
- Supports programmable birth/survive rules, toroidal or dead-boundary edges, a row load port, registered row readout, a generation counter, population count and a still-life detect.
- Serves as the engine behind the simulation display benches.

---
 rtl/gol_engine.sv | 200 ++++++++++++++++++++
 tb/tb_gol_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_engine.sv
// gol_engine: row-serial Conway-style cellular automaton engine.
// Builds one generation per step in a shadow buffer, then commits it.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   wrap_en                    1 = toroidal edges, 0 = dead boundary
//   birth_mask, survive_mask   rule masks indexed by neighbour count
//   load_valid/ready/row/data  row write port (IDLE only)
//   step_valid/ready           request one generation
//   rd_addr, rd_data           registered committed-row readout
//   busy, done                 generation in progress / commit pulse
//   gen_count, pop_count       generations committed / live cells
//   stable                     last generation equals its predecessor
module gol_engine #(
  parameter int NUM_ROWS = 20,
  parameter int NUM_COLS = 32,
  parameter int GEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrap_en,
  input  logic [8:0]              birth_mask,
  input  logic [8:0]              survive_mask,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [$clog2(NUM_ROWS)-1:0] load_row,
  input  logic [NUM_COLS-1:0]     load_data,
  input  logic                    step_valid,
  output logic                    step_ready,
  input  logic [$clog2(NUM_ROWS)-1:0] rd_addr,
  output logic [NUM_COLS-1:0]     rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [GEN_W-1:0]        gen_count,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0] pop_count,
  output logic                    stable
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int PW = $clog2(NUM_ROWS*NUM_COLS+1);
  localparam logic [RW-1:0] LAST = RW'(NUM_ROWS-1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [NUM_COLS-1:0] cells  [NUM_ROWS];
  logic [NUM_COLS-1:0] shadow [NUM_ROWS];

  logic [RW-1:0] ptr;
  logic          wrap_q;
  logic [8:0]    birth_q;
  logic [8:0]    surv_q;
  logic [PW-1:0] pop_acc;
  logic          stable_acc;

  logic accept;
  logic load_go;

  logic [NUM_COLS-1:0] row_up, row_mid, row_dn;
  logic [NUM_COLS-1:0] up_lo, up_hi, mid_lo, mid_hi;
  logic [NUM_COLS-1:0] dn_lo, dn_hi;
  logic [NUM_COLS-1:0] next_row;
  logic [PW-1:0]       row_pop;
  logic [3:0]          cnt;

  assign load_ready = (state_q == IDLE);
  assign step_ready = load_ready && !load_valid;
  assign load_go    = load_valid && load_ready;
  assign accept     = step_valid && step_ready;
  assign busy       = (state_q != IDLE);

  // Bit c of the result holds v[c-1]; column -1 wraps or reads dead.
  function automatic logic [NUM_COLS-1:0] nb_lo(
    input logic [NUM_COLS-1:0] v,
    input logic                w
  );
    return {v[NUM_COLS-2:0], w & v[NUM_COLS-1]};
  endfunction

  // Bit c of the result holds v[c+1]; column NUM_COLS wraps or reads dead.
  function automatic logic [NUM_COLS-1:0] nb_hi(
    input logic [NUM_COLS-1:0] v,
    input logic                w
  );
    return {w & v[0], v[NUM_COLS-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = COMPUTE;
      COMPUTE: if (ptr == LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Neighbour rows of the row under computation.
  always_comb begin
    row_mid = cells[ptr];
    row_up  = '0;
    row_dn  = '0;
    if (ptr == '0) begin
      if (wrap_q) row_up = cells[LAST];
    end else begin
      row_up = cells[ptr - 1'b1];
    end
    if (ptr == LAST) begin
      if (wrap_q) row_dn = cells[0];
    end else begin
      row_dn = cells[ptr + 1'b1];
    end
  end

  assign up_lo  = nb_lo(row_up, wrap_q);
  assign up_hi  = nb_hi(row_up, wrap_q);
  assign mid_lo = nb_lo(row_mid, wrap_q);
  assign mid_hi = nb_hi(row_mid, wrap_q);
  assign dn_lo  = nb_lo(row_dn, wrap_q);
  assign dn_hi  = nb_hi(row_dn, wrap_q);

  always_comb begin
    next_row = '0;
    row_pop  = '0;
    cnt      = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      cnt = {3'b0, up_lo[c]} + {3'b0, row_up[c]}
          + {3'b0, up_hi[c]} + {3'b0, mid_lo[c]}
          + {3'b0, mid_hi[c]} + {3'b0, dn_lo[c]}
          + {3'b0, row_dn[c]} + {3'b0, dn_hi[c]};
      next_row[c] = row_mid[c] ? surv_q[cnt]
                               : birth_q[cnt];
      row_pop = row_pop + PW'(next_row[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      wrap_q     <= 1'b0;
      birth_q    <= '0;
      surv_q     <= '0;
      pop_acc    <= '0;
      stable_acc <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      gen_count  <= '0;
      pop_count  <= '0;
      stable     <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        cells[r]  <= '0;
        shadow[r] <= '0;
      end
    end else begin
      done    <= 1'b0;
      rd_data <= (rd_addr <= LAST) ? cells[rd_addr] : '0;
      unique case (state_q)
        IDLE: begin
          if (load_go && (load_row <= LAST))
            cells[load_row] <= load_data;
          if (accept) begin
            wrap_q     <= wrap_en;
            birth_q    <= birth_mask;
            surv_q     <= survive_mask;
            ptr        <= '0;
            pop_acc    <= '0;
            stable_acc <= 1'b1;
          end
        end
        COMPUTE: begin
          shadow[ptr] <= next_row;
          pop_acc     <= pop_acc + row_pop;
          stable_acc  <= stable_acc
                       && (next_row == row_mid);
          ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
        COMMIT: begin
          for (int r = 0; r < NUM_ROWS; r++)
            cells[r] <= shadow[r];
          gen_count <= gen_count + 1'b1;
          pop_count <= pop_acc;
          stable    <= stable_acc;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_engine.sv
// tb_gol_engine: directed checks of gol_engine (20x32, B3/S23 and
// custom rules, both edge modes, handshake and mid-step reset).
module tb_gol_engine;

  localparam int NR = 20;
  localparam int NC = 32;
  localparam int GW = 16;
  localparam int RW = $clog2(NR);
  localparam int PW = $clog2(NR*NC+1);
  localparam logic [8:0] B3  = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrap_en = 1'b0;
  logic [8:0]    birth_mask = B3;
  logic [8:0]    survive_mask = S23;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [RW-1:0] load_row = '0;
  logic [NC-1:0] load_data = '0;
  logic          step_valid = 1'b0;
  logic          step_ready;
  logic [RW-1:0] rd_addr = '0;
  logic [NC-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [GW-1:0] gen_count;
  logic [PW-1:0] pop_count;
  logic          stable;

  int total = 0;
  int bad = 0;
  logic [NC-1:0] expv [NR];

  gol_engine #(
    .NUM_ROWS(NR),
    .NUM_COLS(NC),
    .GEN_W(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wrap_en(wrap_en),
    .birth_mask(birth_mask),
    .survive_mask(survive_mask),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_row(load_row),
    .load_data(load_data),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .gen_count(gen_count),
    .pop_count(pop_count),
    .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input int r, input logic [NC-1:0] d);
    load_valid = 1'b1;
    load_row   = RW'(r);
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic read_row(input int r, output logic [NC-1:0] d);
    rd_addr = RW'(r);
    tick();
    d = rd_data;
  endtask

  task automatic clr_exp();
    for (int r = 0; r < NR; r++) expv[r] = '0;
  endtask

  task automatic check_all(input string tag);
    logic [NC-1:0] d;
    for (int r = 0; r < NR; r++) begin
      read_row(r, d);
      chk($sformatf("%s_r%0d", tag, r), 64'(d), 64'(expv[r]));
    end
  endtask

  // Step and wait for done; optionally scramble the rule inputs
  // right after accept.
  task automatic do_step(input logic w,
                         input logic [8:0] b,
                         input logic [8:0] s,
                         input logic scramble,
                         output int lat);
    wrap_en      = w;
    birth_mask   = b;
    survive_mask = s;
    step_valid   = 1'b1;
    tick();
    step_valid = 1'b0;
    if (scramble) begin
      wrap_en      = ~w;
      birth_mask   = ~b;
      survive_mask = ~s;
    end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [NC-1:0] d;

    // 1: reset after random preload
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < NR; r += 3) load(r, $urandom);
    do_step(1'b1, B3, S23, 1'b0, lat);
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_gen", 64'(gen_count), 64'd0);
    chk("rst_pop", 64'(pop_count), 64'd0);
    chk("rst_stable", 64'(stable), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    clr_exp();
    check_all("rst");

    // 2: blinker, dead edges
    load(5, 32'h70);
    do_step(1'b0, B3, S23, 1'b0, lat);
    chk("blk_lat", 64'(lat), 64'd21);
    chk("blk_gen1", 64'(gen_count), 64'd1);
    chk("blk_pop1", 64'(pop_count), 64'd3);
    chk("blk_stab1", 64'(stable), 64'd0);
    tick();
    chk("blk_done_once", 64'(done), 64'd0);
    chk("blk_busy_low", 64'(busy), 64'd0);
    clr_exp();
    expv[4] = 32'h20;
    expv[5] = 32'h20;
    expv[6] = 32'h20;
    check_all("blk1");
    rd_addr = RW'(31);
    tick();
    chk("rd_oob", 64'(rd_data), 64'd0);
    do_step(1'b0, B3, S23, 1'b0, lat);
    chk("blk_gen2", 64'(gen_count), 64'd2);
    chk("blk_pop2", 64'(pop_count), 64'd3);
    chk("blk_stab2", 64'(stable), 64'd0);
    clr_exp();
    expv[5] = 32'h70;
    check_all("blk2");

    // 3: still-life block
    do_reset();
    load(8, 32'h0C00);
    load(9, 32'h0C00);
    do_step(1'b0, B3, S23, 1'b0, lat);
    chk("blk4_pop", 64'(pop_count), 64'd4);
    chk("blk4_stab", 64'(stable), 64'd1);
    clr_exp();
    expv[8] = 32'h0C00;
    expv[9] = 32'h0C00;
    check_all("still");

    // 4: edge modes
    do_reset();
    load(0, 32'h8000_0003);
    do_step(1'b0, B3, S23, 1'b0, lat);
    chk("edge0_pop", 64'(pop_count), 64'd0);
    clr_exp();
    check_all("edge0");
    load(0, 32'h8000_0003);
    do_step(1'b1, B3, S23, 1'b0, lat);
    chk("edge1_pop", 64'(pop_count), 64'd3);
    chk("edge1_gen", 64'(gen_count), 64'd2);
    clr_exp();
    expv[19] = 32'h1;
    expv[0]  = 32'h1;
    expv[1]  = 32'h1;
    check_all("edge1");

    // 5: programmable rule on a glider, masks scrambled while busy
    do_reset();
    load(1, 32'h4);
    load(2, 32'h8);
    load(3, 32'hE);
    do_step(1'b0, 9'h000, 9'h1FF, 1'b0, lat);
    chk("rule_stab", 64'(stable), 64'd1);
    chk("rule_pop", 64'(pop_count), 64'd5);
    clr_exp();
    expv[1] = 32'h4;
    expv[2] = 32'h8;
    expv[3] = 32'hE;
    check_all("rule");
    do_step(1'b0, 9'h000, 9'h1FF, 1'b1, lat);
    chk("scr_stab", 64'(stable), 64'd1);
    chk("scr_pop", 64'(pop_count), 64'd5);
    check_all("scr");

    // 6: handshake and abort
    do_reset();
    wrap_en      = 1'b0;
    birth_mask   = B3;
    survive_mask = S23;
    load_valid = 1'b1;
    load_row   = RW'(2);
    load_data  = 32'hF;
    step_valid = 1'b1;
    #1;
    chk("hs_step_rdy", 64'(step_ready), 64'd0);
    chk("hs_load_rdy", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    step_valid = 1'b0;
    chk("hs_no_step", 64'(busy), 64'd0);
    read_row(2, d);
    chk("hs_loaded", 64'(d), 64'h0F);
    do_step(1'b0, B3, S23, 1'b0, lat);
    chk("hs_gen1", 64'(gen_count), 64'd1);
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    chk("hs_busy", 64'(busy), 64'd1);
    chk("hs_lrdy_busy", 64'(load_ready), 64'd0);
    chk("hs_srdy_busy", 64'(step_ready), 64'd0);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_gen", 64'(gen_count), 64'd0);
    chk("ab_pop", 64'(pop_count), 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("ab_nodone", 64'(seen), 64'd0);
    chk("ab_gen2", 64'(gen_count), 64'd0);
    clr_exp();
    check_all("ab");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
